// File: rtl/pgm_pkg.sv
// Shared definitions for the DDRAM arbiter: owner and state encodings,
// the DDRAM word-address width and the loader byte-enable decode.
package pgm_pkg;

  localparam int ADDR_W     = 29;
  localparam int DDR_W      = 64;
  localparam int PASS_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_VID = 2'd1,
    OWN_SND = 2'd2
  } owner_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_LOAD    = 3'd4
  } state_t;

  // A 16-bit loader word lands in one of four lanes of the 64-bit DDRAM word.
  function automatic logic [7:0] load_be(input logic [1:0] lane);
    logic [7:0] be;
    case (lane)
      2'd0:    be = 8'h03;
      2'd1:    be = 8'h0C;
      2'd2:    be = 8'h30;
      default: be = 8'hC0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/pgm_sync_bit.sv
// Single-bit synchronizer of configurable depth.
// Ports:
//   clk, reset_n : destination clock, asynchronous active-low reset
//   i_d          : asynchronous input
//   o_q          : input resynchronized to clk after STAGES flops
module pgm_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift form works for any depth including a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Three-way DDRAM read arbiter (CPU > video > audio, with audio starvation
// guard) plus a pass-through write path for the ROM loader.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   ioctl_*                           : loader interface (download, wr, addr, dout, index)
//   {cpu,vid,snd}_req/_addr           : level requests (foreign domain) and word addresses
//   {cpu,vid,snd}_ack/_data           : 4-phase acknowledge and captured read data
//   ddram_*                           : DDRAM command/data interface
//   timeout_err                       : one-cycle pulse on a forced completion
module pgm_ddram_arbiter
  import pgm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic              cpu_req,
  input  logic              vid_req,
  input  logic              snd_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] snd_addr,
  output logic              cpu_ack,
  output logic              vid_ack,
  output logic              snd_ack,
  output logic [DDR_W-1:0]  cpu_data,
  output logic [DDR_W-1:0]  vid_data,
  output logic [DDR_W-1:0]  snd_data,
  output logic              ddram_rd,
  output logic              ddram_we,
  output logic [ADDR_W-1:0] ddram_addr,
  output logic [DDR_W-1:0]  ddram_din,
  output logic [7:0]        ddram_be,
  input  logic [DDR_W-1:0]  ddram_dout,
  input  logic              ddram_busy,
  input  logic              ddram_dout_ready,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_grant_own;
  logic [ADDR_W-1:0] r_addr, w_grant_addr;
  logic [2:0]        r_ack;
  logic [DDR_W-1:0]  r_data [3];
  logic [2:0]        r_pass;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_tmo_err;

  logic [2:0] w_req;      // synchronized requests, indexed by owner
  logic [2:0] w_own_oh;   // one-hot of the latched owner
  logic       w_own_req;
  logic       w_grant, w_capture, w_timeout, w_release;
  logic       w_unused;

  assign w_unused = ioctl_addr[0];

  pgm_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cpu (
    .clk(clk), .reset_n(reset_n), .i_d(cpu_req), .o_q(w_req[0]));
  pgm_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vid (
    .clk(clk), .reset_n(reset_n), .i_d(vid_req), .o_q(w_req[1]));
  pgm_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_snd (
    .clk(clk), .reset_n(reset_n), .i_d(snd_req), .o_q(w_req[2]));

  assign w_own_oh[0] = (r_owner == OWN_CPU);
  assign w_own_oh[1] = (r_owner == OWN_VID);
  assign w_own_oh[2] = (r_owner == OWN_SND);
  assign w_own_req   = |(w_own_oh & w_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_own  = OWN_CPU;
    w_grant_addr = cpu_addr;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_release    = 1'b0;
    ddram_rd     = 1'b0;
    ddram_we     = 1'b0;
    ddram_be     = 8'hFF;
    ddram_addr   = r_addr;
    ddram_din    = '0;
    case (r_state)
      ST_IDLE: begin
        if (ioctl_download) begin
          w_state_nxt = ST_LOAD;
        end else if (|w_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
          // Audio jumps the queue once it has been passed over PASS_LIMIT times.
          if (w_req[2] && (r_pass == 3'(PASS_LIMIT) || !(w_req[0] || w_req[1]))) begin
            w_grant_own  = OWN_SND;
            w_grant_addr = snd_addr;
          end else if (w_req[0]) begin
            w_grant_own  = OWN_CPU;
            w_grant_addr = cpu_addr;
          end else begin
            w_grant_own  = OWN_VID;
            w_grant_addr = vid_addr;
          end
        end
      end
      ST_ISSUE: begin
        ddram_rd = 1'b1;
        if (!ddram_busy) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ddram_dout_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (r_wcnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!w_own_req) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ddram_we   = ioctl_wr && (ioctl_index == 8'd0);
        ddram_addr = {5'b0, ioctl_addr[26:3]};
        ddram_din  = {4{ioctl_dout}};
        ddram_be   = load_be(ioctl_addr[2:1]);
        if (!ioctl_download) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner   <= OWN_CPU;
      r_addr    <= '0;
      r_pass    <= '0;
      r_wcnt    <= '0;
      r_tmo_err <= 1'b0;
      r_ack     <= '0;
      for (int i = 0; i < 3; i++) r_data[i] <= '0;
    end else begin
      r_tmo_err <= w_timeout;
      if (w_grant) begin
        r_owner <= w_grant_own;
        r_addr  <= w_grant_addr;
        // Only grants to others while audio waits count as passes.
        if (w_grant_own == OWN_SND || !w_req[2]) begin
          r_pass <= '0;
        end else if (r_pass != 3'(PASS_LIMIT)) begin
          r_pass <= r_pass + 3'd1;
        end
      end
      if (r_state == ST_WAIT) begin
        r_wcnt <= r_wcnt + 1'b1;
      end else begin
        r_wcnt <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        if (w_own_oh[i] && (w_capture || w_timeout)) begin
          r_data[i] <= w_capture ? ddram_dout : {DDR_W{1'b1}};
          r_ack[i]  <= 1'b1;
        end else if (w_own_oh[i] && w_release) begin
          r_ack[i]  <= 1'b0;
        end
      end
    end
  end

  assign cpu_ack     = r_ack[0];
  assign vid_ack     = r_ack[1];
  assign snd_ack     = r_ack[2];
  assign cpu_data    = r_data[0];
  assign vid_data    = r_data[1];
  assign snd_data    = r_data[2];
  assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
module tb_pgm_ddram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        cpu_req, vid_req, snd_req;
  logic [28:0] cpu_addr, vid_addr, snd_addr;
  logic        cpu_ack, vid_ack, snd_ack;
  logic [63:0] cpu_data, vid_data, snd_data;
  logic        ddram_rd, ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [63:0] ddram_dout;
  logic        ddram_busy, ddram_dout_ready;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  pgm_ddram_arbiter #(.SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .cpu_req(cpu_req), .vid_req(vid_req), .snd_req(snd_req),
    .cpu_addr(cpu_addr), .vid_addr(vid_addr), .snd_addr(snd_addr),
    .cpu_ack(cpu_ack), .vid_ack(vid_ack), .snd_ack(snd_ack),
    .cpu_data(cpu_data), .vid_data(vid_data), .snd_data(snd_data),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [7:0]  idx;
    logic [26:0] addr;
    logic [15:0] dout;
    logic        exp_we;
    logic [7:0]  exp_be;
    logic [28:0] exp_addr;
    logic [63:0] exp_din;
  } ld_vec_t;

  ld_vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int w);
    case (w)
      0:       return cpu_ack;
      1:       return vid_ack;
      2:       return snd_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_rd();
    int n = 0;
    while (!ddram_rd && n < 60) begin
      tick();
      n++;
    end
    chk("rd_seen", 64'(ddram_rd), 64'd1);
  endtask

  // Waits for the read strobe, optionally holds busy, then returns data
  // after 'delay' cycles and reports which ack rose.
  task automatic serve(input int delay, input int busy_cyc, input logic [63:0] d,
                       output int who, output logic [28:0] a, output int rdc);
    who = -1;
    a   = '0;
    rdc = 0;
    wait_rd();
    if (ddram_rd) begin
      a   = ddram_addr;
      rdc = 1;
      if (busy_cyc > 0) begin
        ddram_busy = 1'b1;
        for (int i = 0; i < busy_cyc; i++) begin
          tick();
          if (ddram_rd) rdc++;
        end
        ddram_busy = 1'b0;
      end
      for (int i = 0; i < delay; i++) begin
        tick();
        if (ddram_rd) rdc++;
      end
      ddram_dout       = d;
      ddram_dout_ready = 1'b1;
      tick();
      ddram_dout_ready = 1'b0;
      if (cpu_ack)      who = 0;
      else if (vid_ack) who = 1;
      else if (snd_ack) who = 2;
    end
  endtask

  task automatic wait_ack_low(input int w);
    int n = 0;
    while (ack_of(w) && n < 20) begin
      tick();
      n++;
    end
    chk("ack_release", 64'(ack_of(w)), 64'd0);
  endtask

  initial begin
    int          who, rdc, n, snd_g;
    logic [28:0] a;
    logic [63:0] exp_cpu, exp_vid;

    vt[0] = '{1'b1, 8'd0, 27'h0000006, 16'hABCD, 1'b1, 8'hC0, 29'h0,      64'hABCDABCDABCDABCD};
    vt[1] = '{1'b1, 8'd0, 27'h0000000, 16'h1234, 1'b1, 8'h03, 29'h0,      64'h1234123412341234};
    vt[2] = '{1'b1, 8'd0, 27'h000002A, 16'h5A5A, 1'b1, 8'h0C, 29'h5,      64'h5A5A5A5A5A5A5A5A};
    vt[3] = '{1'b1, 8'd0, 27'h7FFFFFC, 16'hFFFF, 1'b1, 8'h30, 29'hFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vt[4] = '{1'b1, 8'd1, 27'h000000E, 16'h0F0F, 1'b0, 8'hC0, 29'h1,      64'h0F0F0F0F0F0F0F0F};
    vt[5] = '{1'b0, 8'd0, 27'h0000010, 16'h8001, 1'b0, 8'h03, 29'h2,      64'h8001800180018001};

    reset_n = 1'b0;
    ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
    cpu_req = 0; vid_req = 0; snd_req = 0;
    cpu_addr = 29'h20; vid_addr = 29'h40; snd_addr = 29'h60;
    ddram_dout = '0; ddram_busy = 0; ddram_dout_ready = 0;
    repeat (3) tick();

    chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("rst_acks", 64'({vid_ack, snd_ack}), 64'd0);
    chk("rst_data", cpu_data | vid_data | snd_data, 64'd0);
    chk("rst_rd_we", 64'({ddram_rd, ddram_we}), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    chk("idle_be", 64'(ddram_be), 64'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single CPU read with latency, one-cycle strobe and 4-phase ack.
    cpu_req = 1'b1;
    n = 0;
    while (!ddram_rd && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    serve(5, 0, 64'h1122334455667788, who, a, rdc);
    exp_cpu = 64'h1122334455667788;
    chk("cpu_owner", 64'(who), 64'd0);
    chk("cpu_addr", 64'(a), 64'h20);
    chk("cpu_rd_once", 64'(rdc), 64'd1);
    chk("cpu_data", cpu_data, exp_cpu);
    chk("vid_data_untouched", vid_data, 64'd0);
    repeat (4) tick();
    chk("cpu_ack_held", 64'(cpu_ack), 64'd1);
    cpu_req = 1'b0;
    wait_ack_low(0);

    // Simultaneous CPU and video: CPU first, video after release; busy stretch.
    cpu_req = 1'b1;
    vid_req = 1'b1;
    serve(1, 0, 64'hA0A0A0A0A0A0A0A0, who, a, rdc);
    exp_cpu = 64'hA0A0A0A0A0A0A0A0;
    chk("prio_first", 64'(who), 64'd0);
    chk("prio_vid_wait", 64'(vid_ack), 64'd0);
    cpu_req = 1'b0;
    wait_ack_low(0);
    chk("no_grant_in_release", 64'(ddram_rd), 64'd0);
    serve(2, 2, 64'hB1B1B1B1B1B1B1B1, who, a, rdc);
    exp_vid = 64'hB1B1B1B1B1B1B1B1;
    chk("prio_second", 64'(who), 64'd1);
    chk("vid_addr", 64'(a), 64'h40);
    chk("busy_rd_cycles", 64'(rdc), 64'd3);
    chk("vid_data", vid_data, exp_vid);
    chk("cpu_data_kept", cpu_data, exp_cpu);
    vid_req = 1'b0;
    wait_ack_low(1);

    // Audio starvation guard.
    cpu_req = 1'b1;
    vid_req = 1'b1;
    snd_req = 1'b1;
    snd_g   = 0;
    for (int g = 1; g <= 6; g++) begin
      serve(1, 0, 64'hC000000000000000 | 64'(g), who, a, rdc);
      if (who == 2 || who < 0) begin
        if (who == 2) snd_g = g;
        break;
      end
      if (who == 0) begin
        exp_cpu = 64'hC000000000000000 | 64'(g);
        cpu_req = 1'b0;
      end else begin
        exp_vid = 64'hC000000000000000 | 64'(g);
        vid_req = 1'b0;
      end
      wait_ack_low(who);
      cpu_req = 1'b1;
      vid_req = 1'b1;
    end
    chk("snd_grant_index", 64'(snd_g), 64'd5);
    chk("snd_data", snd_data, 64'hC000000000000005);
    chk("snd_addr", 64'(a), 64'h60);
    cpu_req = 1'b0;
    vid_req = 1'b0;
    snd_req = 1'b0;
    wait_ack_low(2);
    chk("starve_cpu_data", cpu_data, exp_cpu);

    // Timeout: dout_ready never comes.
    repeat (2) tick();
    vid_req = 1'b1;
    wait_rd();
    n = 0;
    while (!timeout_err && n < 400) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd256);
    chk("tmo_ack", 64'(vid_ack), 64'd1);
    chk("tmo_data", vid_data, 64'hFFFFFFFFFFFFFFFF);
    tick();
    chk("tmo_pulse_once", 64'(timeout_err), 64'd0);
    vid_req = 1'b0;
    wait_ack_low(1);

    // Loader request during WAIT: read finishes, then LOAD.
    repeat (2) tick();
    cpu_req = 1'b1;
    wait_rd();
    tick();
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 27'h6;
    repeat (2) tick();
    chk("dl_no_we_in_wait", 64'(ddram_we), 64'd0);
    chk("dl_be_in_wait", 64'(ddram_be), 64'hFF);
    ddram_dout       = 64'hD5D5D5D5D5D5D5D5;
    ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    chk("dl_cpu_ack", 64'(cpu_ack), 64'd1);
    chk("dl_cpu_data", cpu_data, 64'hD5D5D5D5D5D5D5D5);
    cpu_req = 1'b0;
    wait_ack_low(0);
    tick();
    for (int i = 0; i < 6; i++) begin
      ioctl_wr    = vt[i].wr;
      ioctl_index = vt[i].idx;
      ioctl_addr  = vt[i].addr;
      ioctl_dout  = vt[i].dout;
      #1;
      chk($sformatf("load_we[%0d]", i),   64'(ddram_we),   64'(vt[i].exp_we));
      chk($sformatf("load_be[%0d]", i),   64'(ddram_be),   64'(vt[i].exp_be));
      chk($sformatf("load_addr[%0d]", i), 64'(ddram_addr), 64'(vt[i].exp_addr));
      chk($sformatf("load_din[%0d]", i),  ddram_din,       vt[i].exp_din);
      tick();
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    chk("load_exit_be", 64'(ddram_be), 64'hFF);
    chk("load_exit_rd", 64'(ddram_rd), 64'd0);

    // Reset during WAIT; late dout_ready must be ignored.
    snd_req = 1'b1;
    wait_rd();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_acks", 64'({cpu_ack, vid_ack, snd_ack}), 64'd0);
    chk("mid_rst_data", cpu_data | vid_data | snd_data, 64'd0);
    chk("mid_rst_rd_we", 64'({ddram_rd, ddram_we}), 64'd0);
    chk("mid_rst_tmo", 64'(timeout_err), 64'd0);
    snd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    ddram_dout       = 64'h1234567812345678;
    ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    tick();
    chk("late_ready_no_ack", 64'(snd_ack), 64'd0);
    chk("late_ready_no_data", snd_data, 64'd0);
    chk("late_ready_no_rd", 64'(ddram_rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
